// File: rtl/key_entry_buffer_pkg.sv
// rtl/key_entry_buffer_pkg.sv - shared lock package: key codes and entry FSM states
package key_entry_buffer_pkg;

   localparam logic [3:0] KEY_DIGIT_MIN  = 4'h0;
   localparam logic [3:0] KEY_DIGIT_MAX  = 4'h9;
   localparam logic [3:0] KEY_LETTER_MIN = 4'hA;
   localparam logic [3:0] KEY_LETTER_MAX = 4'hD;
   localparam logic [3:0] KEY_STAR       = 4'hE;
   localparam logic [3:0] KEY_HASH       = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_EMIT  = 2'd2
   } entry_state_e;

   function automatic logic is_terminator(input logic [3:0] code);
      return (code == KEY_STAR) || (code == KEY_HASH);
   endfunction

endpackage

// File: rtl/key_entry_buffer_if.sv
// rtl/key_entry_buffer_if.sv - keypad strobe in, completed entry out
interface key_entry_buffer_if #(
   parameter int MAX_KEYS = 4
);
   logic                    key_valid;
   logic [3:0]              key_code;
   logic                    entry_valid;
   logic [4*MAX_KEYS-1:0]   entry_data;
   logic [3:0]              entry_len;
   logic                    entry_term;
   logic                    entry_err;

   modport master (
      output key_valid, key_code,
      input  entry_valid, entry_data, entry_len, entry_term, entry_err
   );

   modport slave (
      input  key_valid, key_code,
      output entry_valid, entry_data, entry_len, entry_term, entry_err
   );
endinterface

// File: rtl/key_entry_buffer_inactivity_timer.sv
// rtl/key_entry_buffer_inactivity_timer.sv - inactivity_timer: pulses expired after CYCLES idle run cycles
module inactivity_timer #(
   parameter int unsigned CYCLES = 250_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic run,
   output logic expired
);
   localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] cnt_q;

   // A restart in the firing cycle wins, so a late key never times out.
   assign expired = run && !restart && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (reset || restart || !run || (cnt_q == LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/key_entry_buffer.sv
// rtl/key_entry_buffer.sv - collects keypad digits into one entry terminated by '*' or '#'
module key_entry_buffer
   import key_entry_buffer_pkg::*;
#(
   parameter int          MAX_KEYS       = 4,
   parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   key_entry_buffer_if.slave   kif,
   output logic                timeout,
   output logic [3:0]          key_count,
   output logic                busy
);
   localparam int         DW      = 4 * MAX_KEYS;
   localparam logic [3:0] MAX_CNT = 4'(MAX_KEYS);

   entry_state_e  state_q;
   logic [DW-1:0] buf_q, shift_d, entry_data_q;
   logic [3:0]    count_q, entry_len_q;
   logic          ovf_q, entry_valid_q, entry_term_q, entry_err_q, timeout_q;
   logic          accept, key_term, tmr_expired;

   assign accept   = kif.key_valid && enable && !clear;
   assign key_term = is_terminator(kif.key_code);

   always_comb begin
      shift_d      = buf_q << 4;
      shift_d[3:0] = kif.key_code;
   end

   inactivity_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (accept),
      .run     (state_q == ST_ENTRY),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         buf_q         <= '0;
         count_q       <= '0;
         ovf_q         <= 1'b0;
         entry_valid_q <= 1'b0;
         entry_data_q  <= '0;
         entry_len_q   <= '0;
         entry_term_q  <= 1'b0;
         entry_err_q   <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         entry_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
         if (clear) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (accept && key_term) begin
                     entry_data_q  <= '0;
                     entry_len_q   <= '0;
                     entry_term_q  <= (kif.key_code == KEY_HASH);
                     entry_err_q   <= 1'b0;
                     entry_valid_q <= 1'b1;
                     state_q       <= ST_EMIT;
                  end else if (accept) begin
                     buf_q   <= DW'(kif.key_code);
                     count_q <= 4'd1;
                     state_q <= ST_ENTRY;
                  end
               end
               ST_ENTRY: begin
                  if (accept && key_term) begin
                     entry_data_q  <= buf_q;
                     entry_len_q   <= count_q;
                     entry_term_q  <= (kif.key_code == KEY_HASH);
                     entry_err_q   <= ovf_q;
                     entry_valid_q <= 1'b1;
                     state_q       <= ST_EMIT;
                  end else if (accept) begin
                     // A full buffer keeps the first MAX_KEYS keys and only flags overflow.
                     if (count_q < MAX_CNT) begin
                        buf_q   <= shift_d;
                        count_q <= count_q + 4'd1;
                     end else begin
                        ovf_q <= 1'b1;
                     end
                  end else if (tmr_expired) begin
                     timeout_q <= 1'b1;
                     buf_q     <= '0;
                     count_q   <= '0;
                     ovf_q     <= 1'b0;
                     state_q   <= ST_IDLE;
                  end
               end
               ST_EMIT: begin
                  buf_q   <= '0;
                  count_q <= '0;
                  ovf_q   <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign kif.entry_valid = entry_valid_q;
   assign kif.entry_data  = entry_data_q;
   assign kif.entry_len   = entry_len_q;
   assign kif.entry_term  = entry_term_q;
   assign kif.entry_err   = entry_err_q;
   assign timeout         = timeout_q;
   assign key_count       = count_q;
   assign busy            = (state_q == ST_ENTRY);
endmodule

// File: tb/tb_key_entry_buffer.sv
// tb/tb_key_entry_buffer.sv - vector table, timeout sequences and randomized model comparison
module tb_key_entry_buffer;
   localparam int MK = 4;
   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       reset, enable, clear;
   logic       timeout, busy;
   logic [3:0] key_count;

   key_entry_buffer_if #(.MAX_KEYS(MK)) kif();

   key_entry_buffer #(.MAX_KEYS(MK), .TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .clear     (clear),
      .kif       (kif),
      .timeout   (timeout),
      .key_count (key_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic        to;
      logic        busy;
      logic        term;
      logic        err;
      logic [3:0]  len;
      logic [3:0]  cnt;
      logic [15:0] data;
   } obs_t;

   typedef struct {
      logic       rst, en, clr, kv;
      logic [3:0] code;
      obs_t       exp;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   logic [3:0] mkeys[$];
   bit         movf, memit;
   int         midle;
   obs_t       mexp;

   function automatic obs_t observe();
      obs_t o;
      o.v    = kif.entry_valid;
      o.to   = timeout;
      o.busy = busy;
      o.term = kif.entry_term;
      o.err  = kif.entry_err;
      o.len  = kif.entry_len;
      o.cnt  = key_count;
      o.data = kif.entry_data;
      return o;
   endfunction

   task automatic check_obs(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual v=%b to=%b busy=%b term=%b err=%b len=%0d cnt=%0d data=%h required v=%b to=%b busy=%b term=%b err=%b len=%0d cnt=%0d data=%h",
                  name, act.v, act.to, act.busy, act.term, act.err, act.len, act.cnt, act.data,
                  exp.v, exp.to, exp.busy, exp.term, exp.err, exp.len, exp.cnt, exp.data);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic r, e, c, k, input logic [3:0] code,
                               input logic v, to, b, t, er, input logic [3:0] len, cnt,
                               input logic [15:0] data);
      vec_t x;
      x.rst = r; x.en = e; x.clr = c; x.kv = k; x.code = code;
      x.exp.v = v; x.exp.to = to; x.exp.busy = b; x.exp.term = t; x.exp.err = er;
      x.exp.len = len; x.exp.cnt = cnt; x.exp.data = data;
      vecs.push_back(x);
   endfunction

   task automatic drive(input logic r, e, c, k, input logic [3:0] code);
      reset = r; enable = e; clear = c; kif.key_valid = k; kif.key_code = code;
      @(posedge clk);
      #1;
   endtask

   // Entry rules stated directly: a list of keys, an overflow bit, a pending emit.
   task automatic model_step(input logic r, e, c, k, input logic [3:0] code);
      bit acc;
      int d;
      acc     = k && e && !c;
      mexp.v  = 1'b0;
      mexp.to = 1'b0;
      if (r) begin
         mkeys.delete(); movf = 0; memit = 0; midle = 0; mexp = '0;
      end else if (c || memit) begin
         mkeys.delete(); movf = 0; memit = 0; midle = 0;
      end else if (acc) begin
         midle = 0;
         if (code >= 4'hE) begin
            d = 0;
            foreach (mkeys[i]) d = d * 16 + int'(mkeys[i]);
            mexp.data = d[15:0];
            mexp.len  = 4'(mkeys.size());
            mexp.term = (code == 4'hF);
            mexp.err  = movf;
            mexp.v    = 1'b1;
            memit     = 1;
         end else if (mkeys.size() < MK) begin
            mkeys.push_back(code);
         end else begin
            movf = 1;
         end
      end else if (mkeys.size() > 0) begin
         midle++;
         if (midle >= TO) begin
            mexp.to = 1'b1;
            mkeys.delete(); movf = 0; midle = 0;
         end
      end
      mexp.cnt  = 4'(mkeys.size());
      mexp.busy = (mkeys.size() > 0) && !memit;
   endtask

   initial begin
      int to_pulses, to_at, ev_pulses, quiet;
      logic r, e, c, k;
      logic [3:0] code;
      int sel;

      reset = 1'b1; enable = 1'b0; clear = 1'b0; kif.key_valid = 1'b0; kif.key_code = 4'h0;

      add(1,1,0,0,4'h0, 0,0,0,0,0,0,0,16'h0000);
      add(0,1,0,1,4'h4, 0,0,1,0,0,0,1,16'h0000);
      add(0,1,0,1,4'h6, 0,0,1,0,0,0,2,16'h0000);
      add(0,1,0,1,4'h9, 0,0,1,0,0,0,3,16'h0000);
      add(0,1,0,1,4'h3, 0,0,1,0,0,0,4,16'h0000);
      add(0,1,0,1,4'hF, 1,0,0,1,0,4,4,16'h4693);
      add(0,1,0,0,4'h0, 0,0,0,1,0,4,0,16'h4693);
      add(0,1,0,1,4'hA, 0,0,1,1,0,4,1,16'h4693);
      add(0,1,0,1,4'hE, 1,0,0,0,0,1,1,16'h000A);
      add(0,1,0,0,4'h0, 0,0,0,0,0,1,0,16'h000A);
      add(0,1,0,1,4'h1, 0,0,1,0,0,1,1,16'h000A);
      add(0,1,0,1,4'h2, 0,0,1,0,0,1,2,16'h000A);
      add(0,1,0,1,4'h3, 0,0,1,0,0,1,3,16'h000A);
      add(0,1,0,1,4'h4, 0,0,1,0,0,1,4,16'h000A);
      add(0,1,0,1,4'h5, 0,0,1,0,0,1,4,16'h000A);
      add(0,1,0,1,4'hF, 1,0,0,1,1,4,4,16'h1234);
      add(0,1,0,0,4'h0, 0,0,0,1,1,4,0,16'h1234);
      add(0,1,0,1,4'h5, 0,0,1,1,1,4,1,16'h1234);
      add(0,1,1,1,4'h6, 0,0,0,1,1,4,0,16'h1234);
      add(0,1,0,1,4'hF, 1,0,0,1,0,0,0,16'h0000);
      add(0,1,0,0,4'h0, 0,0,0,1,0,0,0,16'h0000);
      add(0,1,0,1,4'h1, 0,0,1,1,0,0,1,16'h0000);
      add(0,1,0,1,4'h2, 0,0,1,1,0,0,2,16'h0000);
      add(1,1,0,0,4'h0, 0,0,0,0,0,0,0,16'h0000);
      add(0,1,0,1,4'hF, 1,0,0,1,0,0,0,16'h0000);
      add(0,1,0,0,4'h0, 0,0,0,1,0,0,0,16'h0000);
      add(0,0,0,1,4'h7, 0,0,0,1,0,0,0,16'h0000);
      add(0,0,0,1,4'hF, 0,0,0,1,0,0,0,16'h0000);
      add(0,1,0,1,4'h8, 0,0,1,1,0,0,1,16'h0000);
      add(0,1,0,1,4'hF, 1,0,0,1,0,1,1,16'h0008);
      add(0,1,0,1,4'h9, 0,0,0,1,0,1,0,16'h0008);
      add(0,1,0,1,4'hE, 1,0,0,0,0,0,0,16'h0000);
      add(0,1,0,0,4'h0, 0,0,0,0,0,0,0,16'h0000);

      drive(1,0,0,0,4'h0);
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].kv, vecs[i].code);
         check_obs($sformatf("vec%0d", i), observe(), vecs[i].exp);
      end

      // Abandoned entry: key 7 then silence until the timeout pulse.
      drive(1,1,0,0,4'h0);
      drive(0,1,0,1,4'h7);
      to_pulses = 0; to_at = 0; ev_pulses = 0;
      for (int s = 1; s <= 30; s++) begin
         drive(0,1,0,0,4'h0);
         if (timeout) begin to_pulses++; if (to_at == 0) to_at = s; end
         if (kif.entry_valid) ev_pulses++;
      end
      check_int("timeout_pulses", to_pulses, 1);
      check_int("timeout_cycle", to_at, TO);
      check_int("timeout_no_entry", ev_pulses, 0);
      check_int("timeout_key_count", int'(key_count), 0);
      check_int("timeout_busy", int'(busy), 0);

      // A key landing on the firing cycle wins and restarts the wait.
      drive(0,1,0,1,4'h7);
      to_pulses = 0;
      for (int s = 1; s < TO; s++) begin
         drive(0,1,0,0,4'h0);
         if (timeout) to_pulses++;
      end
      drive(0,1,0,1,4'h8);
      if (timeout) to_pulses++;
      check_int("late_key_no_timeout", to_pulses, 0);
      check_int("late_key_count", int'(key_count), 2);
      to_at = 0;
      for (int s = 1; s <= 30; s++) begin
         drive(0,1,0,0,4'h0);
         if (timeout && to_at == 0) to_at = s;
      end
      check_int("late_key_timeout_cycle", to_at, TO);

      model_step(1,1,0,0,4'h0);
      drive(1,1,0,0,4'h0);
      quiet = 0;
      for (int i = 0; i < 4000; i++) begin
         r = 0; c = 0; k = 0; e = 1; code = 4'($urandom_range(0, 15));
         if (quiet > 0) begin
            quiet--;
         end else if ($urandom_range(0, 99) == 0) begin
            quiet = $urandom_range(15, 30);
         end else begin
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 39) == 0);
            k = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 9) != 0);
            sel = $urandom_range(0, 7);
            code = (sel < 6) ? 4'($urandom_range(0, 13)) : ((sel == 6) ? 4'hE : 4'hF);
         end
         model_step(r, e, c, k, code);
         drive(r, e, c, k, code);
         check_obs($sformatf("rand%0d", i), observe(), mexp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
